// File: rtl/display_scanner.sv
// Scans eight 4-bit digits onto a common-anode 8-digit display.
// Each digit slot starts with a blank interval (all anodes off) so the segment
// lines settle before an anode turns on. New digit data is taken only at frame
// wrap, so a frame never shows a mix of old and new values. Optional
// leading-zero suppression is applied on top of the per-digit enables.
module display_scanner #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] digits,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  dig_en,
    input  logic        lz_suppress,
    input  logic        load,
    output logic [3:0]  digit_out,
    output logic [7:0]  an,
    output logic        dp,
    output logic        frame
);

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned CNT_W      = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      sh_digits_q, sh_digits_d;
    logic [7:0]       sh_dp_q, sh_dp_d;
    logic [7:0]       sh_en_q, sh_en_d;
    logic             pending_q, pending_d;
    logic [3:0]       digit_out_d;
    logic [7:0]       an_d;
    logic             dp_d;
    logic             frame_d;

    logic             slot_wrap;
    logic             frame_wrap;
    logic [7:0]       visible;
    logic             zero_run;

    // Visibility per digit: enabled and not a leading zero (scanning down from digit 7).
    always_comb begin
        visible  = '0;
        zero_run = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            zero_run   = zero_run && (sh_digits_q[4*i +: 4] == 4'h0);
            visible[i] = sh_en_q[i] && !(lz_suppress && (i > 0) && zero_run);
        end
    end

    // Next-state: slot counter, digit index, blank/on phase, shadow load and outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        idx_d       = idx_q;
        sh_digits_d = sh_digits_q;
        sh_dp_d     = sh_dp_q;
        sh_en_d     = sh_en_q;
        pending_d   = pending_q | load;
        digit_out_d = digit_out;
        an_d        = 8'hFF;
        dp_d        = 1'b1;
        frame_d     = 1'b0;

        slot_wrap  = (cnt_q == CNT_LAST);
        frame_wrap = slot_wrap && (idx_q == IDX_W'(NUM_DIGITS - 1));

        if (slot_wrap) begin
            cnt_d = '0;
            idx_d = idx_q + IDX_W'(1);
        end

        // A request made on the wrap cycle itself is consumed here, not carried over.
        if (frame_wrap) begin
            pending_d = 1'b0;
            frame_d   = 1'b1;
            if (pending_q || load) begin
                sh_digits_d = digits;
                sh_dp_d     = dp_in;
                sh_en_d     = dig_en;
            end
        end

        case (state_q)
            ST_BLANK: if (cnt_q == BLANK_LAST) state_d = ST_ON;
            ST_ON:    if (slot_wrap)           state_d = ST_BLANK;
            default:                           state_d = ST_BLANK;
        endcase

        // Nibble changes only at slot start, so it is stable for the whole slot.
        if (slot_wrap) begin
            digit_out_d = sh_digits_d[{idx_d, 2'b00} +: 4];
        end

        if ((state_d == ST_ON) && visible[idx_d]) begin
            an_d = ~(8'b1 << idx_d);
            dp_d = ~sh_dp_q[idx_d];
        end
    end

    // State and output registers; reset forces all anodes off immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_BLANK;
            cnt_q       <= '0;
            idx_q       <= '0;
            sh_digits_q <= '0;
            sh_dp_q     <= '0;
            sh_en_q     <= '0;
            pending_q   <= 1'b0;
            digit_out   <= 4'h0;
            an          <= 8'hFF;
            dp          <= 1'b1;
            frame       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sh_digits_q <= sh_digits_d;
            sh_dp_q     <= sh_dp_d;
            sh_en_q     <= sh_en_d;
            pending_q   <= pending_d;
            digit_out   <= digit_out_d;
            an          <= an_d;
            dp          <= dp_d;
            frame       <= frame_d;
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner with a short slot (8 cycles, 2 blank).
// Expected per-cycle outputs for each frame are queued from a shadow model and
// popped as the scan runs.
module tb_display_scanner;

    localparam int RD        = 8;
    localparam int BC        = 2;
    localparam int FRAME_LEN = 8 * RD;

    logic        clk;
    logic        rst_n;
    logic [31:0] digits;
    logic [7:0]  dp_in;
    logic [7:0]  dig_en;
    logic        lz_suppress;
    logic        load;
    logic [3:0]  digit_out;
    logic [7:0]  an;
    logic        dp;
    logic        frame;

    logic [13:0] exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          frame_no = 0;

    logic [31:0] m_digits;
    logic [7:0]  m_dp;
    logic [7:0]  m_en;
    logic        m_first;

    display_scanner #(
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits     (digits),
        .dp_in      (dp_in),
        .dig_en     (dig_en),
        .lz_suppress(lz_suppress),
        .load       (load),
        .digit_out  (digit_out),
        .an         (an),
        .dp         (dp),
        .frame      (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Digit i lights if enabled and some digit at or above i is non-zero (or no suppression).
    function automatic logic vis(input int i, input logic lzv);
        logic nz;
        nz = 1'b0;
        for (int j = i; j < 8; j++) begin
            if (m_digits[4*j +: 4] != 4'h0) nz = 1'b1;
        end
        return m_en[i] && (!lzv || (i == 0) || nz);
    endfunction

    task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Queue the 64 expected {frame, digit_out, an, dp} vectors of one frame.
    task automatic push_frame(input logic lzv);
        for (int c = 0; c < FRAME_LEN; c++) begin
            int         s;
            int         k;
            logic       on;
            logic [3:0] nib;
            logic [7:0] a;
            logic       d;
            s   = c / RD;
            k   = c % RD;
            nib = m_digits[4*s +: 4];
            on  = (k >= BC) && vis(s, lzv);
            a   = on ? ~(8'b1 << s) : 8'hFF;
            d   = on ? ~m_dp[s] : 1'b1;
            exp_q.push_back({(c == 0) && !m_first, nib, a, d});
        end
        m_first = 1'b0;
    endtask

    // Run one frame from cycle 0, optionally changing live inputs / pulsing load at cycle lc.
    task automatic run_frame(input logic lzv, input int lc, input logic do_load,
                             input logic [31:0] d, input logic [7:0] p, input logic [7:0] e,
                             input int stop);
        logic loaded;
        loaded      = 1'b0;
        lz_suppress = lzv;
        push_frame(lzv);
        for (int c = 0; c < stop; c++) begin
            load = 1'b0;
            if (exp_q.size() == 0) begin
                failures++;
                $error("FAIL scoreboard_empty frame%0d cyc%0d observed=none expected=entry", frame_no, c);
            end else begin
                check($sformatf("frame%0d_cyc%0d", frame_no, c), {frame, digit_out, an, dp},
                      exp_q.pop_front());
            end
            if (c == lc) begin
                digits = d;
                dp_in  = p;
                dig_en = e;
                load   = do_load;
                if (do_load) loaded = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        load = 1'b0;
        if ((stop == FRAME_LEN) && loaded) begin
            m_digits = digits;
            m_dp     = dp_in;
            m_en     = dig_en;
        end
        frame_no++;
    endtask

    initial begin
        rst_n       = 1'b0;
        digits      = '0;
        dp_in       = '0;
        dig_en      = '0;
        lz_suppress = 1'b0;
        load        = 1'b0;
        m_digits    = '0;
        m_dp        = '0;
        m_en        = '0;
        m_first     = 1'b1;

        // Reset values while held low.
        repeat (3) @(posedge clk);
        #1;
        check("reset_an", {6'd0, an}, {6'd0, 8'hFF});
        check("reset_dp", {13'd0, dp}, {13'd0, 1'b1});
        check("reset_digit_out", {10'd0, digit_out}, 14'd0);
        check("reset_frame", {13'd0, frame}, 14'd0);
        #2 rst_n = 1'b1;
        #1;

        // Frame 0: dark (cleared shadow); load 76543210 mid-frame.
        run_frame(1'b0, 10, 1'b1, 32'h76543210, 8'h00, 8'hFF, FRAME_LEN);
        // Frame 1: counting digits; new data loaded at idx 3 must not tear this frame.
        run_frame(1'b0, 27, 1'b1, 32'h89ABCDEF, 8'h00, 8'hFF, FRAME_LEN);
        // Frame 2: 89ABCDEF; queue the leading-zero pattern.
        run_frame(1'b0, 5, 1'b1, 32'h00000507, 8'h00, 8'hFF, FRAME_LEN);
        // Frame 3: suppression shows 5,0,7; load on the wrap cycle itself.
        run_frame(1'b1, FRAME_LEN - 1, 1'b1, 32'h00000000, 8'h00, 8'hFF, FRAME_LEN);
        // Frame 4: all zero -> only slot 0; live change without load must not take effect.
        run_frame(1'b1, 20, 1'b0, 32'h12345678, 8'h00, 8'hFF, FRAME_LEN);
        // Frame 5: still all zero (wrap-cycle load was not carried over); load enable pattern.
        run_frame(1'b1, 40, 1'b1, 32'h00000507, 8'h04, 8'h05, FRAME_LEN);
        // Frame 6: only slots 0 and 2 lit, DP on slot 2; load full pattern for reset test.
        run_frame(1'b0, 30, 1'b1, 32'h76543210, 8'h00, 8'hFF, FRAME_LEN);
        // Frame 7: stop while slot 4 is lit, then reset asynchronously.
        run_frame(1'b0, -1, 1'b0, 32'h0, 8'h0, 8'h0, 37);
        exp_q.delete();
        #2 rst_n = 1'b0;
        #1;
        check("midreset_an", {6'd0, an}, {6'd0, 8'hFF});
        check("midreset_dp", {13'd0, dp}, {13'd0, 1'b1});
        check("midreset_digit_out", {10'd0, digit_out}, 14'd0);
        check("midreset_frame", {13'd0, frame}, 14'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        m_digits = '0;
        m_dp     = '0;
        m_en     = '0;
        m_first  = 1'b1;

        // Frames 8,9: shadow cleared, nothing pending -> dark despite live inputs.
        run_frame(1'b0, -1, 1'b0, 32'h0, 8'h0, 8'h0, FRAME_LEN);
        run_frame(1'b0, -1, 1'b0, 32'h0, 8'h0, 8'h0, FRAME_LEN);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
